// File: rtl/prog_clk_div.sv
// prog_clk_div: programmable clock divider with boundary-aligned divisor reload (status ports under PROG_CLK_DIV_STATUS_EN)
module prog_clk_div #(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_div,
  output logic                 o_div_clk,
  output logic                 o_tick,
  output logic                 o_err
`ifdef PROG_CLK_DIV_STATUS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_pending
`endif
);
  localparam logic [CNT_WIDTH-1:0] DEF = CNT_WIDTH'(DEFAULT_DIV);
  logic [CNT_WIDTH-1:0] r_cnt, r_nact, r_pdiv;
  logic                 r_pend, r_div_clk, r_err;
  logic [CNT_WIDTH-1:0] w_cnt_nxt, w_nact_nxt;
  logic                 w_tick, w_ok, w_bad;
  // period end detect, load qualification and next counter/divisor
  always_comb begin
    w_tick     = i_en && (r_cnt == r_nact - 1'b1);
    w_ok       = i_load && (i_div >= CNT_WIDTH'(2));
    w_bad      = i_load && (i_div < CNT_WIDTH'(2));
    w_nact_nxt = w_tick ? (w_ok ? i_div : (r_pend ? r_pdiv : r_nact)) : r_nact;
    w_cnt_nxt  = w_tick ? '0 : r_cnt + CNT_WIDTH'(i_en);
  end
  // state update; o_div_clk is derived from the next counter so it lines up with r_cnt
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_nact    <= DEF;
      r_pdiv    <= DEF;
      r_pend    <= 1'b0;
      r_div_clk <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_nact    <= w_nact_nxt;
      r_pdiv    <= w_ok ? i_div : r_pdiv;
      r_pend    <= w_tick ? 1'b0 : (r_pend | w_ok);
      r_div_clk <= w_cnt_nxt >= (w_nact_nxt >> 1);
      r_err     <= w_bad;
    end
  end
  assign o_div_clk = r_div_clk;
  assign o_tick    = w_tick;
  assign o_err     = r_err;
`ifdef PROG_CLK_DIV_STATUS_EN
  assign o_cnt     = r_cnt;
  assign o_pending = r_pend;
`endif
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: randomized + directed check of prog_clk_div against a period-level reference model
module tb_prog_clk_div;
  logic       clk = 1'b0;
  logic       i_reset = 1'b1, i_en = 1'b0, i_load = 1'b0;
  logic [7:0] i_div = 8'd0;
  logic       o_div_clk, o_tick, o_err;
`ifdef PROG_CLK_DIV_STATUS_EN
  logic [7:0] o_cnt;
  logic       o_pending;
`endif
  int vectors = 0, miscompares = 0;
  int pos = 0, n = 12, pv = 0, cnum = 0, last_tk = -1, per = 0;
  bit pend = 0, merr = 0, mtick = 0, seen_tick = 0;

  prog_clk_div #(.CNT_WIDTH(8), .DEFAULT_DIV(12)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_load(i_load), .i_div(i_div),
    .o_div_clk(o_div_clk), .o_tick(o_tick), .o_err(o_err)
`ifdef PROG_CLK_DIV_STATUS_EN
    , .o_cnt(o_cnt), .o_pending(o_pending)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cnum);
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit ld, input int dv);
    bit ok;
    @(negedge clk);
    i_reset = rst; i_en = en; i_load = ld; i_div = 8'(dv);
    #1;
    mtick = en && (pos == n - 1);
    chk("tick", int'(o_tick), int'(mtick));
    seen_tick = o_tick;
    if (o_tick) begin
      if (last_tk >= 0) per = cnum - last_tk;
      last_tk = cnum;
    end
    @(posedge clk);
    cnum++;
    if (rst) begin
      pos = 0; n = 12; pend = 0; pv = 0; merr = 0; last_tk = -1;
    end else begin
      merr = ld && dv < 2;
      ok = ld && dv >= 2;
      if (mtick) begin
        n = ok ? dv : (pend ? pv : n);
        pos = 0; pend = 0;
      end else begin
        pos += int'(en);
        if (ok) begin pend = 1; pv = dv; end
      end
    end
    #1;
    chk("div_clk", int'(o_div_clk), int'(pos >= n / 2));
    chk("err", int'(o_err), int'(merr));
`ifdef PROG_CLK_DIV_STATUS_EN
    chk("cnt", int'(o_cnt), pos);
    chk("pending", int'(o_pending), int'(pend));
`endif
  endtask

  task automatic run_ticks(input int k);
    int seen = 0;
    for (int i = 0; i < 600 && seen < k; i++) begin
      cyc(0, 1, 0, 0);
      seen += int'(seen_tick);
    end
    chk("tick_wait", seen, k);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 1, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    chk("rst_div_clk", int'(o_div_clk), 0);
    run_ticks(1); run_ticks(1);
    chk("period_default", per, 12);
    idle(3); cyc(0, 1, 1, 5);
    run_ticks(1); chk("period_before_reload", per, 12);
    run_ticks(1); chk("period_5a", per, 5);
    run_ticks(1); chk("period_5b", per, 5);
    cyc(1, 0, 0, 0); idle(2);
    cyc(0, 1, 1, 1); chk("err_div1", int'(o_err), 1);
    cyc(0, 1, 1, 0); chk("err_div0", int'(o_err), 1);
    cyc(0, 1, 0, 0); chk("err_clear", int'(o_err), 0);
    run_ticks(2); chk("period_after_bad", per, 12);
    idle(2); cyc(0, 1, 1, 7); cyc(0, 1, 1, 9);
    run_ticks(1); chk("period_pre_9", per, 12);
    run_ticks(1); chk("period_9", per, 9);
    cyc(1, 0, 0, 0); run_ticks(1); idle(3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    run_ticks(1); chk("period_frozen", per, 16);
    cyc(1, 0, 0, 0); run_ticks(1); idle(7); cyc(0, 1, 1, 20);
    cyc(1, 1, 0, 0);
    chk("rst_mid_div_clk", int'(o_div_clk), 0);
    run_ticks(2); chk("period_after_rst", per, 12);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 5) == 0, int'($urandom_range(0, 20)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the counter and divisor.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 12, giving the divisor used after reset; legal range 2..2^CNT_WIDTH-1.
REQ-003 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_en, input, width 1: count enable; low freezes the divider.
REQ-006 The block SHALL have port i_load, input, width 1: one-cycle request to load a new divisor.
REQ-007 The block SHALL have port i_div, input, width CNT_WIDTH: new divisor N, sampled when i_load=1.
REQ-008 The block SHALL have port o_div_clk, output, width 1: divided clock, registered.
REQ-009 The block SHALL have port o_tick, output, width 1: one-cycle pulse on the last cycle of each period.
REQ-010 The block SHALL have port o_err, output, width 1: one-cycle pulse when a loaded divisor is rejected.

Function
REQ-011 The block SHALL hold an active divisor N_act and a period counter r_cnt that counts 0..N_act-1 and then wraps to 0, advancing only when i_en=1.
REQ-012 o_div_clk SHALL be low while r_cnt < floor(N_act/2) and high while r_cnt >= floor(N_act/2); for odd N it is high one cycle longer than it is low.
REQ-013 o_div_clk SHALL be registered so that it changes in the same cycle as the r_cnt value it reflects, with no combinational path from any input.
REQ-014 o_tick SHALL be 1 exactly when r_cnt = N_act-1 and i_en=1, and 0 otherwise.
REQ-015 i_load=1 with 2 <= i_div SHALL capture i_div into a pending register and set a pending flag.
REQ-016 A pending divisor SHALL become N_act only at a period boundary (a cycle where o_tick=1), so the next period starts at r_cnt=0 with the new N; no truncated or extended period is produced.
REQ-017 i_load=1 in the same cycle as o_tick=1 SHALL make the new i_div effective for the immediately following period.
REQ-018 Repeated loads before a boundary SHALL overwrite the pending value; the last accepted value wins.
REQ-019 i_load=1 with i_div < 2 SHALL be rejected: o_err=1 for one cycle, and the pending value, the pending flag and N_act are unchanged.
REQ-020 With i_en=0, r_cnt, o_div_clk and N_act SHALL hold, o_tick SHALL be 0, and loads SHALL still be captured as pending.
REQ-021 The counter compare SHALL use the full CNT_WIDTH, and r_cnt SHALL never exceed N_act-1.

Reset
REQ-022 With i_reset=1 at a rising edge of i_clk: r_cnt=0, N_act=DEFAULT_DIV, pending flag cleared, o_div_clk=0, o_tick=0, o_err=0.
REQ-023 Reset SHALL take priority over i_en and i_load, and a reset asserted mid-period SHALL discard any pending divisor.

Configuration
REQ-024 Macro PROG_CLK_DIV_STATUS_EN, when defined, SHALL add output o_cnt (width CNT_WIDTH, equal to r_cnt) and output o_pending (width 1, the pending flag); both reset to 0.
REQ-025 Without PROG_CLK_DIV_STATUS_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Scenario: reset, then i_en=1 with DEFAULT_DIV=12 -> o_div_clk low for 6 cycles, high for 6, period 12; o_tick on every 12th cycle.
REQ-027 Scenario: load i_div=5 mid-period -> current 12-cycle period completes unchanged, then periods of 5 with o_div_clk low 2 cycles and high 3.
REQ-028 Scenario: load i_div=1, then i_div=0 -> o_err pulses once per load; period stays 12; o_pending (if enabled) remains 0.
REQ-029 Scenario: load 7 then 9 within one period -> next period is 9; 7 never appears.
REQ-030 Scenario: i_en=0 for 4 cycles at r_cnt=3 -> outputs frozen, o_tick=0; the period resumes and the total elapsed is 12+4 cycles.
REQ-031 Scenario: i_reset=1 at r_cnt=8 with a pending load of 20 -> next cycle r_cnt=0 and o_div_clk=0; period is 12 and 20 is never applied.
